regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
// - Write-side front end of the 32x32 register file: accepts results from the ALU and
//   load/store unit over valid/ready channels and buffers them in an in-order queue.
// - Drains one entry per cycle onto the register file write port.
// - Tells the issue stage which source registers still have writes pending.
// - Sits between the execute/memory stages and the register file write port.
// PARAMETERS
// - DEPTH  4  queue entries (power of two, >=2)
// - XLEN   32 data width
// - AW     5  register address width (32 registers)
// PORTS
// - clk          in   1      clock; all state changes on rising edge
// - rst          in   1      synchronous, active-high reset
// - alu_valid    in   1      ALU result offered
// - alu_ready    out  1      ALU result accepted when valid&ready
// - alu_rd       in   AW     ALU destination register
// - alu_data     in   XLEN   ALU result
// - lsu_valid    in   1      load result offered
// - lsu_ready    out  1      load result accepted when valid&ready
// - lsu_rd       in   AW     load destination register
// - lsu_data     in   XLEN   load data
// - rf_hold      in   1      register file port busy; suppresses drain
// - rf_write_en  out  1      register file write strobe
// - rf_addr_w    out  AW     register file write address
// - rf_data_w    out  XLEN   register file write data
// - chk_addr_a   in   AW     issue-stage source A query
// - chk_addr_b   in   AW     issue-stage source B query
// - pend_a       out  1      queued write targets chk_addr_a
// - pend_b       out  1      queued write targets chk_addr_b
// - q_count      out  log2(DEPTH)+1  entries occupied
// BEHAVIOUR
// - Reset: queue empty, q_count=0, rf_write_en=0, rf_addr_w=0, rf_data_w=0,
//   pend_a=pend_b=0, round-robin pointer favours ALU. Reset mid-drain discards all entries.
// - Ready signals: alu_ready = lsu_ready = (q_count < DEPTH), taken from state only.
//   No combinational path from rf_hold to ready. A full queue does not accept while popping.
// - Arbitration:
//   - At most one push per cycle.
//   - If both channels are valid, grant alternates by round robin. The losing channel
//     sees ready=0 that cycle and holds its data.
//   - The pointer toggles only when both channels were valid.
// - rd==0: the transfer completes (handshake honoured) but nothing is enqueued.
//   An rd==0 transfer does not count as a grant.
// - Drain: rf_write_en = !empty & !rf_hold. rf_addr_w and rf_data_w come from the queue
//   head, registered outputs with no comb path from inputs. The head pops on that edge.
// - Latency: a push at edge N produces rf_write_en high in the cycle after N (if no hold).
//   The register file commits the write at edge N+1.
// - Simultaneous push and pop: allowed when not full; q_count unchanged.
// - Pointers wrap modulo DEPTH.
// - Order: writes reach the register file in acceptance order. WAW order is preserved.
// - pend_x: 1 iff any valid entry has rd==chk_addr_x and chk_addr_x!=0. This includes
//   the head being written this cycle. Combinational from state and chk_addr.
// CONFIGURATION
// - WB_BYPASS_EN defined: adds outputs byp_data_a/byp_data_b (XLEN).
//   - Each carries the data of the youngest queued entry matching chk_addr_x.
//   - pend_x then means "bypass valid"; the issue stage reads byp_data_x instead of stalling.
// - WB_BYPASS_EN undefined: no bypass ports and no youngest-match mux.
//   - pend_x is a pure stall request.
// STRUCTURE
// - regfile_pkg: XLEN, AW constants and the wb_entry_t struct {rd[AW], data[XLEN]}.
//   Shared with the register file and issue stage.
// - Sub-module wb_fifo: parameterised sync FIFO of wb_entry_t with push/pop/count and a
//   flat entry/valid view for the pend and bypass match logic.
// - Top level: arbiter, rd==0 filter, match logic.
// TESTING
// - Single ALU push rd=5 data=0xDEADBEEF, no hold -> next cycle rf_write_en=1,
//   addr=5, data=0xDEADBEEF; q_count returns to 0.
// - ALU and LSU both valid for 4 cycles (rd=1..4) -> grants alternate ALU, LSU, ALU, LSU.
//   Drain order matches acceptance order.
// - rf_hold=1 with 5 pushes, DEPTH=4 -> ready drops after 4; q_count=4; 5th held.
//   Release hold -> 4 writes on consecutive cycles, then the 5th is accepted.
// - Push rd=0 data=0x1234 -> handshake completes, q_count stays 0, no rf_write_en.
// - Queue entries rd=7 (0x11) then rd=7 (0x22), chk_addr_a=7 -> pend_a=1.
//   With WB_BYPASS_EN, byp_data_a=0x22. pend_a clears after both drain.
// - Assert rst with 3 entries queued -> next cycle q_count=0, rf_write_en=0, pend_a=pend_b=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types: data/address widths and the writeback entry.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. Besides push/pop/count it exposes every
// slot rotated into age order (index 0 = head/oldest) with a valid bit, so the
// match logic upstream can find pending destinations and the youngest match.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_ent,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t [DEPTH-1:0] age_ent,
  output logic [DEPTH-1:0]      age_vld
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: callers guarantee push only when not full, pop only when not empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Age-ordered view; pointer wrap is free because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_ent[i] = mem_q[rd_ptr_q + PW'(i)];
      age_vld[i] = (CW'(i) < cnt_q);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: round-robin arbitration between the
// ALU and LSU result channels, rd==0 filtering, an in-order queue draining one
// write per cycle, and pending-write lookup for two issue-stage sources.
// Optional feature: define WB_BYPASS_EN to add byp_data_a/byp_data_b, carrying the
// youngest queued data for each matching source.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [AW-1:0]         lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  rf_hold,
  output logic                  rf_write_en,
  output logic [AW-1:0]         rf_addr_w,
  output logic [XLEN-1:0]       rf_data_w,
  input  logic [AW-1:0]         chk_addr_a,
  input  logic [AW-1:0]         chk_addr_b,
  output logic                  pend_a,
  output logic                  pend_b,
`ifdef WB_BYPASS_EN
  output logic [XLEN-1:0]       byp_data_a,
  output logic [XLEN-1:0]       byp_data_b,
`endif
  output logic [$clog2(DEPTH):0] q_count
);

  wb_entry_t             push_ent, head;
  wb_entry_t [DEPTH-1:0] age_ent;
  logic [DEPTH-1:0]      age_vld;
  logic                  fifo_full, fifo_empty;
  logic                  both, alu_fire, lsu_fire, push;
  logic                  rr_q, rr_d;  // 1 = LSU wins the next contested cycle

  // Arbitration: readiness depends only on occupancy plus the round-robin loser mask.
  always_comb begin
    both      = alu_valid & lsu_valid;
    alu_ready = !fifo_full & !(both & rr_q);
    lsu_ready = !fifo_full & !(both & !rr_q);
    alu_fire  = alu_valid & alu_ready;
    lsu_fire  = lsu_valid & lsu_ready;
    push_ent  = lsu_fire ? '{rd: lsu_rd, data: lsu_data} : '{rd: alu_rd, data: alu_data};
    // rd==0 completes the handshake but is dropped and does not count as a grant.
    push      = (alu_fire & (alu_rd != '0)) | (lsu_fire & (lsu_rd != '0));
    rr_d      = rr_q ^ (both & push);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  assign rf_write_en = !fifo_empty & !rf_hold;
  assign rf_addr_w   = head.rd;
  assign rf_data_w   = head.data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent (push_ent),
    .pop      (rf_write_en),
    .head     (head),
    .count    (q_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .age_ent  (age_ent),
    .age_vld  (age_vld)
  );

  // Pending-write match; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
`ifdef WB_BYPASS_EN
    byp_data_a = '0;
    byp_data_b = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i] && (chk_addr_a != '0) && (age_ent[i].rd == chk_addr_a)) begin
        pend_a = 1'b1;
`ifdef WB_BYPASS_EN
        byp_data_a = age_ent[i].data;
`endif
      end
      if (age_vld[i] && (chk_addr_b != '0) && (age_ent[i].rd == chk_addr_b)) begin
        pend_b = 1'b1;
`ifdef WB_BYPASS_EN
        byp_data_b = age_ent[i].data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all
// compared against a queue-based model of the writeback buffer.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0]   alu_rd, lsu_rd, rf_addr_w, chk_addr_a, chk_addr_b;
  logic [XLEN-1:0] alu_data, lsu_data, rf_data_w;
  logic            rf_hold, rf_write_en, pend_a, pend_b;
  logic [2:0]      q_count;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] byp_data_a, byp_data_b;
`endif

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_hold(rf_hold), .rf_write_en(rf_write_en), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .pend_a(pend_a), .pend_b(pend_b),
`ifdef WB_BYPASS_EN
    .byp_data_a(byp_data_a), .byp_data_b(byp_data_b),
`endif
    .q_count(q_count)
  );

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  ent_t       mq[$];        // model of queued writes, oldest first
  ent_t       aq[$], lq[$]; // pending requests per source
  logic [4:0] wlog[$];      // addresses the DUT actually wrote
  bit         rr;           // model: 1 = LSU favoured on contention
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: present source heads, compare against the model, then advance it.
  task automatic cyc();
    bit   both, ar, lr, we, pa, pb;
    ent_t e;
    logic [31:0] ba, bb;
    alu_valid = (aq.size() > 0);
    alu_rd    = alu_valid ? aq[0].rd : 5'd0;
    alu_data  = alu_valid ? aq[0].data : 32'd0;
    lsu_valid = (lq.size() > 0);
    lsu_rd    = lsu_valid ? lq[0].rd : 5'd0;
    lsu_data  = lsu_valid ? lq[0].data : 32'd0;
    #1;
    both = alu_valid && lsu_valid;
    ar   = (mq.size() < DEPTH) && !(both && rr);
    lr   = (mq.size() < DEPTH) && !(both && !rr);
    we   = (mq.size() > 0) && !rf_hold;
    if (!rst) begin
      chk("alu_ready", 32'(alu_ready), 32'(ar));
      chk("lsu_ready", 32'(lsu_ready), 32'(lr));
      chk("rf_write_en", 32'(rf_write_en), 32'(we));
      chk("q_count", 32'(q_count), 32'(mq.size()));
      if (mq.size() > 0) begin
        chk("rf_addr_w", 32'(rf_addr_w), 32'(mq[0].rd));
        chk("rf_data_w", rf_data_w, mq[0].data);
      end
      pa = 0; pb = 0; ba = 0; bb = 0;
      foreach (mq[i]) begin
        if (chk_addr_a != 0 && mq[i].rd == chk_addr_a) begin pa = 1; ba = mq[i].data; end
        if (chk_addr_b != 0 && mq[i].rd == chk_addr_b) begin pb = 1; bb = mq[i].data; end
      end
      chk("pend_a", 32'(pend_a), 32'(pa));
      chk("pend_b", 32'(pend_b), 32'(pb));
`ifdef WB_BYPASS_EN
      if (pa) chk("byp_data_a", byp_data_a, ba);
      if (pb) chk("byp_data_b", byp_data_b, bb);
`endif
      if (rf_write_en) wlog.push_back(rf_addr_w);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      rr = 0;
    end else begin
      if (we) void'(mq.pop_front());
      if (alu_valid && ar) begin
        e = aq.pop_front();
        if (e.rd != 0) begin mq.push_back(e); if (both) rr = !rr; end
      end
      if (lsu_valid && lr) begin
        e = lq.pop_front();
        if (e.rd != 0) begin mq.push_back(e); if (both) rr = !rr; end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1; rf_hold = 0; chk_addr_a = 0; chk_addr_b = 0;
    alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
    @(negedge clk);
    run(2);
    rst = 0;
    chk_addr_a = 7; chk_addr_b = 3;
    #1;
    chk("rst_count", 32'(q_count), 0);
    chk("rst_we", 32'(rf_write_en), 0);
    chk("rst_addr", 32'(rf_addr_w), 0);
    chk("rst_data", rf_data_w, 0);
    chk("rst_pend", 32'({pend_a, pend_b}), 0);

    // Single ALU write
    aq.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    cyc();
    #1;
    chk("t1_we", 32'(rf_write_en), 1);
    chk("t1_addr", 32'(rf_addr_w), 5);
    chk("t1_data", rf_data_w, 32'hDEADBEEF);
    run(2);
    chk("t1_count", 32'(q_count), 0);

    // Contention: grants alternate, drain follows acceptance order
    wlog.delete();
    aq.push_back('{rd: 5'd1, data: 32'h101}); aq.push_back('{rd: 5'd3, data: 32'h303});
    lq.push_back('{rd: 5'd2, data: 32'h202}); lq.push_back('{rd: 5'd4, data: 32'h404});
    run(8);
    chk("t2_nwr", 32'(wlog.size()), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("t2_order", 32'(wlog[i]), 32'(i + 1));

    // Hold with 5 pushes: fills at 4, releases in order
    rf_hold = 1;
    for (int i = 0; i < 5; i++) aq.push_back('{rd: 5'(8 + i), data: 32'(i)});
    run(6);
    chk("t3_full", 32'(q_count), 4);
    chk("t3_ready", 32'(alu_ready), 0);
    chk("t3_left", 32'(aq.size()), 1);
    rf_hold = 0;
    wlog.delete();
    run(8);
    chk("t3_nwr", 32'(wlog.size()), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk("t3_order", 32'(wlog[i]), 32'(8 + i));

    // rd==0 is accepted but dropped
    aq.push_back('{rd: 5'd0, data: 32'h1234});
    cyc();
    #1;
    chk("t4_taken", 32'(aq.size()), 0);
    chk("t4_count", 32'(q_count), 0);
    chk("t4_we", 32'(rf_write_en), 0);
    run(1);

    // WAW on rd 7: pending, youngest data visible
    rf_hold = 1; chk_addr_a = 7;
    aq.push_back('{rd: 5'd7, data: 32'h11}); aq.push_back('{rd: 5'd7, data: 32'h22});
    run(3);
    chk("t5_pend", 32'(pend_a), 1);
`ifdef WB_BYPASS_EN
    chk("t5_byp", byp_data_a, 32'h22);
`endif
    rf_hold = 0;
    run(3);
    chk("t5_clear", 32'(pend_a), 0);

    // Reset with entries queued
    rf_hold = 1; chk_addr_a = 1; chk_addr_b = 2;
    for (int i = 1; i <= 3; i++) aq.push_back('{rd: 5'(i), data: 32'(i * 3)});
    run(4);
    chk("t6_pre", 32'(q_count), 3);
    rst = 1;
    run(1);
    rst = 0; rf_hold = 0;
    #1;
    chk("t6_count", 32'(q_count), 0);
    chk("t6_we", 32'(rf_write_en), 0);
    chk("t6_pend", 32'({pend_a, pend_b}), 0);
    run(1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rf_hold    = ($urandom_range(0, 3) == 0);
      chk_addr_a = 5'($urandom_range(0, 7));
      chk_addr_b = 5'($urandom_range(0, 7));
      if (aq.size() < 2 && $urandom_range(0, 1) == 1)
        aq.push_back('{rd: 5'($urandom_range(0, 7)), data: $urandom});
      if (lq.size() < 2 && $urandom_range(0, 1) == 1)
        lq.push_back('{rd: 5'($urandom_range(0, 7)), data: $urandom});
      cyc();
    end
    rf_hold = 0;
    for (int c = 0; c < 40 && (mq.size() > 0 || aq.size() > 0 || lq.size() > 0); c++) cyc();
    chk("drain_done", 32'(mq.size() + aq.size() + lq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
